rst_seq_ctrl: RTL

Reset sequencer for the clock/reset generator (CRG). It holds a bank of downstream active-low resets asserted, then releases them one at a time in fixed index order with programmable spacing. It runs automatically after its own reset and again on each software/system request. It is the issuing end of the reset-release path: it drives the staggered releases that downstream delay-based release logic waits for.

---
 rtl/crg_pkg.sv | 18 +
 rtl/rst_seq_timer.sv | 36 +++
 rtl/rst_seq_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/crg_pkg.sv
// rtl/crg_pkg.sv - shared CRG types and reset sequencer defaults
package crg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } rst_seq_state_e;

  localparam int unsigned RST_SEQ_NUM_DEFAULT  = 4;
  localparam int unsigned RST_SEQ_HOLD_DEFAULT = 8;
  localparam int unsigned RST_SEQ_STEP_DEFAULT = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rtl/rst_seq_timer.sv - edge counter that pulses expire on the tc_i-th enabled edge
module rst_seq_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] tc_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Expire is taken on the edge that would make the count reach tc_i, so the counter never wraps.
  assign expire_o = en_i && !clr_i && (cnt_q == tc_i - WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - holds a bank of active-low resets, then releases them in index order
module rst_seq_ctrl
  import crg_pkg::*;
#(
  parameter int unsigned NUM_RST     = RST_SEQ_NUM_DEFAULT,
  parameter int unsigned HOLD_CYCLES = RST_SEQ_HOLD_DEFAULT,
  parameter int unsigned STEP_CYCLES = RST_SEQ_STEP_DEFAULT
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               req_i,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned TW = $clog2(max_u(HOLD_CYCLES, STEP_CYCLES) + 1);
  localparam int unsigned IW = $clog2(NUM_RST + 1);
  localparam logic [TW-1:0] HOLD_TC  = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] STEP_TC  = TW'(STEP_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_RST - 1);

  if (NUM_RST < 1) begin : g_bad_num_rst
    $error("rst_seq_ctrl: NUM_RST must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_ctrl: HOLD_CYCLES must be at least 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("rst_seq_ctrl: STEP_CYCLES must be at least 1");
  end

  rst_seq_state_e   state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             arm_q, arm_d;

  logic             t_clr;
  logic             t_en;
  logic [TW-1:0]    t_tc;
  logic             t_exp;

  rst_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (t_clr),
    .en_i     (t_en),
    .tc_i     (t_tc),
    .expire_o (t_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    arm_d   = 1'b1;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    t_tc    = HOLD_TC;
    unique case (state_q)
      IDLE: begin
        t_clr = 1'b1;
        if (req_i) begin
          state_d = HOLD;
          rst_d   = '0;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      HOLD: begin
        // The edge leaving reset plays the role of the accepting edge, so it is not counted.
        t_en = arm_q;
        t_tc = HOLD_TC;
        if (t_exp) begin
          rst_d[0] = 1'b1;
          idx_d    = IW'(1);
          if (NUM_RST == 1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        t_en = 1'b1;
        t_tc = STEP_TC;
        if (t_exp) begin
          for (int k = 0; k < int'(NUM_RST); k++) begin
            if (idx_q == IW'(k)) begin
              rst_d[k] = 1'b1;
            end
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arst_n_i) begin
      state_q <= HOLD;
      idx_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      arm_q   <= arm_d;
    end
  end

  assign rst_n_o = rst_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
